// File: rtl/bus_slave_regbank.sv
// bus_slave_regbank: bus responder with six scratch registers, an access
// counter and an ID word. Ready and read data come a programmable number
// of wait states after each accepted access.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | waiting for a chip-selected, address-strobed request
//   WAIT    | counting down the wait states of the accepted access
//   RESP    | ready cycle: s_rdy_ low, read data valid, write commits
module bus_slave_regbank #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_cs_,
  input  logic        s_as_,
  input  logic        s_rw,
  input  logic [29:0] s_addr,
  input  logic [31:0] s_wr_data,
  output logic [31:0] s_rd_data,
  output logic        s_rdy_
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Counter is loaded with one less than the wait count: the terminal
  // count of zero is itself the last wait cycle.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [2:0]         addr_q, addr_d;
  logic               rw_q, rw_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [5:0][31:0]   regs_q, regs_d;
  logic [31:0]        acc_q, acc_d;
  logic               rdy_n_q, rdy_n_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [31:0]        rd_mux;
  logic               accept;

  // Upper address bits take no part in decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^s_addr[29:3];

  assign accept    = (state_q == ST_IDLE) && !s_cs_ && !s_as_;
  assign s_rdy_    = rdy_n_q;
  assign s_rd_data = rd_data_q;

  // State, request latches, register file and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      regs_q    <= '0;
      acc_q     <= '0;
      rdy_n_q   <= 1'b1;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      regs_q    <= regs_d;
      acc_q     <= acc_d;
      rdy_n_q   <= rdy_n_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Next state, wait-state down-counter and request capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = s_addr[2:0];
          rw_d    = s_rw;
          wdata_d = s_wr_data;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux over the latched (or just-accepted) register index.
  always_comb begin
    rd_mux = '0;
    case (addr_d)
      3'd0: rd_mux = regs_q[0];
      3'd1: rd_mux = regs_q[1];
      3'd2: rd_mux = regs_q[2];
      3'd3: rd_mux = regs_q[3];
      3'd4: rd_mux = regs_q[4];
      3'd5: rd_mux = regs_q[5];
      3'd6: rd_mux = acc_q;
      default: rd_mux = ID_VALUE;
    endcase
  end

  // Outputs are registered one edge ahead so they line up with RESP.
  always_comb begin
    rdy_n_d   = (state_d != ST_RESP);
    rd_data_d = ((state_d == ST_RESP) && rw_d) ? rd_mux : 32'd0;
  end

  // Write commit and access count on the edge that ends RESP.
  always_comb begin
    regs_d = regs_q;
    acc_d  = acc_q;
    if (state_q == ST_RESP) begin
      acc_d = acc_q + 32'd1;
      if (!rw_q) begin
        for (int i = 0; i < 6; i++) begin
          if (addr_q == 3'(i)) regs_d[i] = wdata_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_slave_regbank.sv
// tb_bus_slave_regbank: three instances (0, 3 and 4 wait states) driven one
// at a time; expected responses are queued at request time and retired by a
// monitor when s_rdy_ goes low.
module tb_bus_slave_regbank;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n  [3];
  logic        as_n  [3];
  logic        rw    [3];
  logic [29:0] addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] rdd   [3];
  logic        rdy_n [3];

  localparam logic [31:0] ID0 = 32'hA0A0_0000;
  localparam logic [31:0] ID1 = 32'h1234_5678;
  localparam logic [31:0] ID2 = 32'hCAFE_F00D;

  always #5 clk = ~clk;

  bus_slave_regbank #(.WAIT_CYCLES(0), .ID_VALUE(ID0)) u_w0 (
    .clk(clk), .reset(reset), .s_cs_(cs_n[0]), .s_as_(as_n[0]), .s_rw(rw[0]),
    .s_addr(addr[0]), .s_wr_data(wd[0]), .s_rd_data(rdd[0]), .s_rdy_(rdy_n[0]));
  bus_slave_regbank #(.WAIT_CYCLES(3), .ID_VALUE(ID1)) u_w3 (
    .clk(clk), .reset(reset), .s_cs_(cs_n[1]), .s_as_(as_n[1]), .s_rw(rw[1]),
    .s_addr(addr[1]), .s_wr_data(wd[1]), .s_rd_data(rdd[1]), .s_rdy_(rdy_n[1]));
  bus_slave_regbank #(.WAIT_CYCLES(4), .ID_VALUE(ID2)) u_w4 (
    .clk(clk), .reset(reset), .s_cs_(cs_n[2]), .s_as_(as_n[2]), .s_rw(rw[2]),
    .s_addr(addr[2]), .s_wr_data(wd[2]), .s_rd_data(rdd[2]), .s_rdy_(rdy_n[2]));

  typedef struct {
    int          id;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  bit          mon_en      = 1'b0;
  logic [31:0] mreg [3][6];
  logic [31:0] mcnt [3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int wc(input int id);
    return (id == 0) ? 0 : ((id == 1) ? 3 : 4);
  endfunction

  function automatic logic [31:0] id_of(input int id);
    return (id == 0) ? ID0 : ((id == 1) ? ID1 : ID2);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Retire one expectation per ready pulse; outside ready, data must be 0.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (rdy_n[i] !== 1'b1) begin
          if (sb.size() == 0) begin
            check_eq("spurious_rdy", {31'd0, rdy_n[i]}, 32'd1);
          end else begin
            mon_e = sb.pop_front();
            check_eq("rdy_dut", i, mon_e.id);
            check_eq("rdy_cycle", cyc, mon_e.cyc);
            check_eq("rd_data", rdd[i], mon_e.data);
          end
        end else begin
          check_eq("idle_data", rdd[i], 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      mcnt[d] = '0;
      for (int r = 0; r < 6; r++) mreg[d][r] = '0;
    end
  endtask

  // One-cycle strobe; when acc is set the access is expected to be taken.
  task automatic drive(input int id, input logic cs, input logic rw_i,
                       input logic [29:0] a, input logic [31:0] d, input bit acc);
    exp_t        e;
    logic [2:0]  r;
    logic [31:0] rv;
    cs_n[id] = cs;
    as_n[id] = 1'b0;
    rw[id]   = rw_i;
    addr[id] = a;
    wd[id]   = d;
    if (acc) begin
      r  = a[2:0];
      rv = (r == 3'd7) ? id_of(id) : ((r == 3'd6) ? mcnt[id] : mreg[id][r]);
      e.id   = id;
      e.cyc  = cyc + 1 + wc(id);
      e.data = rw_i ? rv : 32'd0;
      sb.push_back(e);
      if (!rw_i && r < 3'd6) mreg[id][r] = d;
      mcnt[id] = mcnt[id] + 32'd1;
    end
    tick();
    as_n[id] = 1'b1;
    cs_n[id] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cs_n[i] = 1'b1; as_n[i] = 1'b1; rw[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end
    clear_model();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_rdy", {31'd0, rdy_n[i]}, 32'd1);
      check_eq("rst_data", rdd[i], 32'd0);
    end
    mon_en = 1'b1;

    // Zero wait states: write, ignored strobe while busy, read back.
    drive(0, 1'b0, 1'b0, 30'd2, 32'hDEAD_BEEF, 1'b1);
    drive(0, 1'b0, 1'b0, 30'd2, 32'h0BAD_0BAD, 1'b0);
    drive(0, 1'b0, 1'b1, 30'd2, 32'd0, 1'b1);
    idle(3);

    // Strobe without chip select, then high address bits ignored.
    drive(0, 1'b1, 1'b1, 30'd7, 32'd0, 1'b0);
    idle(2);
    drive(0, 1'b0, 1'b0, 30'h3FFF_FFF9, 32'h1111_2222, 1'b1);
    idle(1);
    drive(0, 1'b0, 1'b1, 30'd1, 32'd0, 1'b1);
    idle(2);

    // Access counter: consecutive reads, dropped write, ID read.
    drive(0, 1'b0, 1'b1, 30'd6, 32'd0, 1'b1);
    idle(1);
    drive(0, 1'b0, 1'b1, 30'd6, 32'd0, 1'b1);
    idle(1);
    drive(0, 1'b0, 1'b0, 30'd6, 32'h0000_FFFF, 1'b1);
    idle(1);
    drive(0, 1'b0, 1'b1, 30'd6, 32'd0, 1'b1);
    idle(1);
    drive(0, 1'b0, 1'b0, 30'd7, 32'h5555_5555, 1'b1);
    idle(1);
    drive(0, 1'b0, 1'b1, 30'd7, 32'd0, 1'b1);
    idle(1);

    // Mixed random traffic.
    for (int k = 0; k < 24; k++) begin
      drive(0, 1'b0, 1'($urandom_range(0, 1)), 30'($urandom), $urandom, 1'b1);
      idle(1 + $urandom_range(0, 1));
    end
    idle(2);

    // Three wait states: ID read with strobes during WAIT and RESP.
    drive(1, 1'b0, 1'b1, 30'd7, 32'd0, 1'b1);
    for (int k = 1; k <= 4; k++) drive(1, 1'b0, 1'b0, 30'(k), 32'hBAD0_0000 + 32'(k), 1'b0);
    drive(1, 1'b0, 1'b0, 30'd5, 32'h0F0F_1234, 1'b1);
    idle(4);
    drive(1, 1'b0, 1'b1, 30'd5, 32'd0, 1'b1);
    idle(4);
    drive(1, 1'b0, 1'b1, 30'd1, 32'd0, 1'b1);
    idle(4);
    drive(1, 1'b0, 1'b1, 30'd6, 32'd0, 1'b1);
    idle(6);

    // Four wait states: seed state, then reset in the middle of a write.
    drive(2, 1'b0, 1'b0, 30'd0, 32'h0000_5A5A, 1'b1);
    idle(5);
    drive(2, 1'b0, 1'b1, 30'd0, 32'd0, 1'b1);
    idle(6);
    cs_n[2] = 1'b0; as_n[2] = 1'b0; rw[2] = 1'b0; addr[2] = 30'd0; wd[2] = 32'h0000_A5A5;
    tick();
    cs_n[2] = 1'b1; as_n[2] = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    idle(7);
    drive(2, 1'b0, 1'b1, 30'd0, 32'd0, 1'b1);
    idle(5);
    drive(2, 1'b0, 1'b1, 30'd6, 32'd0, 1'b1);
    idle(5);
    drive(2, 1'b0, 1'b1, 30'd7, 32'd0, 1'b1);
    idle(8);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
